// File: rtl/rr_sel_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter for three requesters; drives the 2-bit select of a 3:1 operand mux (never 2'b11).
// Latency: one cycle from req to registered sel/grant/out_valid; xfer_done one cycle after each transfer.
// Backpressure: holds sel/grant/out_valid stable while out_ready is low; a withdrawn request returns to IDLE.
// Optional: define RR_BURST_EN to keep a grant for up to BURST_LEN consecutive transfers.
module rr_sel_arbiter #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic [2:0] grant,
  output logic       out_valid,
  output logic       xfer_done
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Reject out-of-range burst lengths at elaboration.
  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst_len
    $error("rr_sel_arbiter: BURST_LEN must be in 1..15");
  end

  logic [0:0] r_state;
  logic [1:0] r_sel;
  logic [2:0] r_grant;
  logic       r_out_valid;
  logic       r_xfer_done;
  logic [1:0] r_ptr;

  logic [0:0] w_state_nxt;
  logic [1:0] w_sel_nxt;
  logic [2:0] w_grant_nxt;
  logic       w_valid_nxt;
  logic [1:0] w_ptr_nxt;
  logic       w_xfer;
  logic       w_req_g;
  logic [1:0] w_ptr_adv;
  logic       w_keep;

  // Mod-3 increment; the pointer and select never hold 3.
  function automatic logic [1:0] f_inc3(input logic [1:0] v);
    f_inc3 = (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // First requester at or after ptr in circular order 0,1,2.
  function automatic logic [1:0] f_pick(input logic [1:0] ptr, input logic [2:0] r);
    logic [1:0] a, b, c;
    a = (ptr == 2'd3) ? 2'd0 : ptr;
    b = f_inc3(a);
    c = f_inc3(b);
    if (r[a])      f_pick = a;
    else if (r[b]) f_pick = b;
    else           f_pick = c;
  endfunction

  function automatic logic [2:0] f_onehot(input logic [1:0] s);
    f_onehot = 3'b001 << s;
  endfunction

  assign w_xfer    = r_out_valid & out_ready;
  assign w_req_g   = req[r_sel];
  assign w_ptr_adv = f_inc3(r_sel);

`ifdef RR_BURST_EN
  logic [3:0] r_beat;
  logic       w_new_grant;

  // Stay on the current requester while it still asks and the burst is not exhausted.
  assign w_keep = w_xfer & w_req_g & ((32'(r_beat) + 32'd1) < BURST_LEN);
  assign w_new_grant = ((r_state == ST_IDLE) & (|req)) |
                       ((r_state == ST_GRANT) & w_xfer & ~w_keep & (|req));

  // Beat counter: cleared on every fresh grant, advanced on each retained transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= 4'd0;
    end else if (w_new_grant) begin
      r_beat <= 4'd0;
    end else if (w_keep) begin
      r_beat <= r_beat + 4'd1;
    end
  end
`else
  // One transfer per grant: always re-arbitrate after a transfer.
  assign w_keep = 1'b0;
`endif

  // Next-state decode: arbitration points are IDLE with any request, or a transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_out_valid;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = f_pick(r_ptr, req);
          w_grant_nxt = f_onehot(w_sel_nxt);
          w_valid_nxt = 1'b1;
        end
      end
      ST_GRANT: begin
        if (w_xfer) begin
          if (!w_keep) begin
            w_ptr_nxt = w_ptr_adv;
            if (|req) begin
              w_sel_nxt   = f_pick(w_ptr_adv, req);
              w_grant_nxt = f_onehot(w_sel_nxt);
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_grant_nxt = 3'b000;
              w_valid_nxt = 1'b0;
            end
          end
        end else if (!w_req_g) begin
          // Granted requester withdrew before being served: pointer stays put.
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 3'b000;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 3'b000;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears outputs immediately and drops any in-flight transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sel       <= 2'd0;
      r_grant     <= 3'b000;
      r_out_valid <= 1'b0;
      r_xfer_done <= 1'b0;
      r_ptr       <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_grant     <= w_grant_nxt;
      r_out_valid <= w_valid_nxt;
      r_xfer_done <= w_xfer;
      r_ptr       <= w_ptr_nxt;
    end
  end

  assign sel       = r_sel;
  assign grant     = r_grant;
  assign out_valid = r_out_valid;
  assign xfer_done = r_xfer_done;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for rr_sel_arbiter: a transaction-level reference model predicts the
// outputs after every clock edge, a negedge monitor pops and compares them.
// Build with RR_BURST_EN defined to exercise bursts of length 3.
module tb_rr_sel_arbiter;

`ifdef RR_BURST_EN
  localparam int DUT_BL   = 3;
  localparam int MODEL_BL = 3;
`else
  localparam int DUT_BL   = 4;
  localparam int MODEL_BL = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic [2:0] grant;
  logic       out_valid;
  logic       xfer_done;

  rr_sel_arbiter #(.BURST_LEN(DUT_BL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid),
    .xfer_done (xfer_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] grant;
    logic       vld;
    logic       xd;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: who holds the grant, the rotation pointer, beats used in the burst.
  bit m_busy;
  int m_ptr;
  int m_sel;
  int m_beat;
  bit m_xd;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input int p, input logic [2:0] r);
    for (int k = 0; k < 3; k++) begin
      if (r[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_sel = 0; m_beat = 0; m_xd = 0;
  endtask

  // One clock edge of the arbitration rules, given the inputs seen at that edge.
  task automatic model_step(input logic [2:0] r, input logic rdy);
    if (!m_busy) begin
      m_xd = 0;
      if (r != 3'b000) begin
        m_busy = 1; m_sel = pick(m_ptr, r); m_beat = 0;
      end
    end else if (rdy) begin
      m_xd = 1;
      if (r[m_sel] && (m_beat + 1 < MODEL_BL)) begin
        m_beat++;
      end else begin
        m_ptr = (m_sel + 1) % 3;
        if (r != 3'b000) begin
          m_sel = pick(m_ptr, r); m_beat = 0;
        end else begin
          m_busy = 0;
        end
      end
    end else begin
      m_xd = 0;
      if (!r[m_sel]) m_busy = 0;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.sel   = 2'(m_sel);
    e.grant = m_busy ? (3'b001 << m_sel) : 3'b000;
    e.vld   = m_busy;
    e.xd    = m_xd;
    return e;
  endfunction

  // Stimulus: apply the model at the edge, then drive the next inputs just after it.
  task automatic tick(input logic [2:0] r, input logic rdy);
    @(posedge clk);
    if (rst_n) begin
      model_step(req, out_ready);
      q.push_back(model_out());
    end
    #1;
    req = r;
    out_ready = rdy;
  endtask

  // Monitor: compare the DUT against the oldest prediction on every falling edge.
  always @(negedge clk) begin
    exp_t e;
    check("sel_legal", int'(sel == 2'b11), 0);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("sel", sel, e.sel);
      check("grant", grant, e.grant);
      check("out_valid", out_valid, e.vld);
      check("xfer_done", xfer_done, e.xd);
    end else if (!rst_n) begin
      check("rst_sel", sel, 0);
      check("rst_grant", grant, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_xfer_done", xfer_done, 0);
    end
  end

  // Assert reset mid-cycle with all requests high; outputs must clear without a clock.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req = 3'b111;
    out_ready = 1'b1;
    #1;
    check("async_sel", sel, 0);
    check("async_grant", grant, 0);
    check("async_out_valid", out_valid, 0);
    check("async_xfer_done", xfer_done, 0);
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    // First edge after release grants requester 0.
    tick(3'b111, 1'b0);
    tick(3'b111, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] r;
    logic       rdy;
    rst_n = 1'b0;
    req = 3'b000;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Rotation with everyone requesting.
    repeat (8) tick(3'b111, 1'b1);
    repeat (3) tick(3'b000, 1'b1);
    // Stall with requesters 1 and 2, then release for one transfer.
    tick(3'b110, 1'b0);
    repeat (5) tick(3'b110, 1'b0);
    tick(3'b110, 1'b1);
    repeat (3) tick(3'b110, 1'b0);
    // Withdrawal of the granted line while stalled.
    repeat (2) tick(3'b111, 1'b0);
    repeat (2) tick(3'b011, 1'b0);
    repeat (2) tick(3'b001, 1'b0);
    repeat (4) tick(3'b111, 1'b1);
    // Single requester, then idle.
    repeat (6) tick(3'b100, 1'b1);
    repeat (3) tick(3'b000, 1'b1);
    // Two requesters back to back (burst pattern when enabled).
    repeat (12) tick(3'b011, 1'b1);
    repeat (2) tick(3'b000, 1'b0);

    mid_reset();

    // Randomized traffic with sticky requests and occasional mid-run resets.
    r = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 3) != 0);
      tick(r, rdy);
      if (i == 1000 || i == 2200) mid_reset();
    end

    repeat (4) tick(3'b000, 1'b1);
    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
